// File: rtl/card_pkg.sv
// Shared constants and bundle types for the card board scanner.
// Geometry, reserved card types and colour constants.
package card_pkg;

  localparam int CARD_W  = 32;
  localparam int CARD_H  = 46;
  localparam int PITCH_X = CARD_W + 2;
  localparam int PITCH_Y = CARD_H + 2;

  localparam logic [5:0] CARD_EMPTY = 6'd63;
  localparam logic [5:0] CARD_BACK  = 6'd54;

  localparam logic [11:0] RGB_BG    = 12'h264;
  localparam logic [11:0] RGB_SEL   = 12'hFF0;
  localparam logic [11:0] RGB_BLANK = 12'h000;

  // Per-pixel sideband that travels alongside the ROM lookup
  typedef struct packed {
    logic valid;
    logic in_board;
    logic ring;
    logic selected;
    logic card;
  } side_t;

endpackage

// File: rtl/card_board_scanner_if.sv
// Address/data bus between the scanner and the Mem_pixel card ROM.
// master: drives pixel_x/pixel_y/card_type, receives card_pixel.
interface card_board_scanner_if;

  logic [5:0]  pixel_x;
  logic [5:0]  pixel_y;
  logic [5:0]  card_type;
  logic [11:0] card_pixel;

  modport master (
    output pixel_x, pixel_y, card_type,
    input  card_pixel
  );

  modport slave (
    input  pixel_x, pixel_y, card_type,
    output card_pixel
  );

endinterface

// File: rtl/slot_table.sv
// Double-buffered slot -> card type table with blanking-time commit.
// Ports: shadow write (wr_*_i), commit request, copy strobe, read port.
module slot_table
  import card_pkg::*;
#(
  parameter int N = 54
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en_i,
  input  logic [5:0] wr_slot_i,
  input  logic [5:0] wr_type_i,
  input  logic       wr_commit_i,
  input  logic       copy_i,
  input  logic [5:0] rd_slot_i,
  output logic [5:0] rd_type_o,
  output logic       pending_o
);

  logic [5:0] shadow_q [N];
  logic [5:0] active_q [N];
  logic       pending_q;
  logic       pending_d;
  logic       copy_go;
  logic       wr_ok;

  assign wr_ok = wr_en_i && (int'(wr_slot_i) < N);

  // A commit arriving in the copy cycle itself is honoured at once
  assign copy_go = copy_i && (pending_q || wr_commit_i);

  always_comb begin
    pending_d = pending_q;
    if (copy_go)
      pending_d = 1'b0;
    else if (wr_commit_i)
      pending_d = 1'b1;
  end

  // Copy reads shadow_q before this cycle's write lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        shadow_q[i] <= CARD_EMPTY;
        active_q[i] <= CARD_EMPTY;
      end
      pending_q <= 1'b0;
    end else begin
      if (copy_go)
        active_q <= shadow_q;
      if (wr_ok)
        shadow_q[wr_slot_i] <= wr_type_i;
      pending_q <= pending_d;
    end
  end

  assign rd_type_o = (int'(rd_slot_i) < N)
                   ? active_q[rd_slot_i]
                   : CARD_EMPTY;
  assign pending_o = pending_q;

endmodule

// File: rtl/card_board_scanner.sv
// VGA position -> board slot/card coordinate, ROM addressing, RGB compose.
// Ports: pixel clock/reset, VGA counters, table writes, selection, ROM bus, rgb.
module card_board_scanner
  import card_pkg::*;
#(
  parameter int          ORG_X   = 14,
  parameter int          ORG_Y   = 300,
  parameter int          COLS    = 18,
  parameter int          ROWS    = 3,
  parameter logic [11:0] BG      = RGB_BG,
  parameter logic [11:0] SEL_RGB = RGB_SEL
) (
  input  logic        clk_25MHz,
  input  logic        rst_n,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic        valid,
  input  logic        wr_en,
  input  logic [5:0]  wr_slot,
  input  logic [5:0]  wr_type,
  input  logic        wr_commit,
  input  logic        sel_en,
  input  logic [5:0]  sel_slot,
  card_board_scanner_if.master mem,
  output logic [11:0] vga_rgb,
  output logic        commit_pending
);

  localparam int N = COLS * ROWS;

  logic [5:0] ox_q, ox_d, col_q, col_d;
  logic [5:0] oy_q, oy_d, row_q, row_d;
  logic       hb_q, hb_d, vb_q, vb_d;

  logic       in_board, ring;
  logic [5:0] slot;
  logic [5:0] rd_type;
  side_t      s1_d, s1_q, s2_q;
  logic [5:0] px_d, px_q, py_d, py_q;
  logic [5:0] type_d, type_q, type2_q;
  logic [11:0] rgb_d, rgb_q;

  // Horizontal position; the _d values are also this cycle's position
  always_comb begin
    ox_d  = ox_q;
    col_d = col_q;
    hb_d  = hb_q;
    if (h_cnt == 10'(ORG_X)) begin
      ox_d  = '0;
      col_d = '0;
      hb_d  = 1'b1;
    end else if (hb_q) begin
      if (ox_q == 6'(PITCH_X - 1)) begin
        ox_d  = '0;
        col_d = col_q + 6'd1;
      end else begin
        ox_d  = ox_q + 6'd1;
      end
      if (col_d == 6'(COLS))
        hb_d = 1'b0;
    end
  end

  // Vertical position advances once per line, at h_cnt == 0
  always_comb begin
    oy_d  = oy_q;
    row_d = row_q;
    vb_d  = vb_q;
    if (h_cnt == '0) begin
      if (v_cnt == 10'(ORG_Y)) begin
        oy_d  = '0;
        row_d = '0;
        vb_d  = 1'b1;
      end else if (vb_q) begin
        if (oy_q == 6'(PITCH_Y - 1)) begin
          oy_d  = '0;
          row_d = row_q + 6'd1;
        end else begin
          oy_d  = oy_q + 6'd1;
        end
        if (row_d == 6'(ROWS))
          vb_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      ox_q  <= '0;
      col_q <= '0;
      hb_q  <= 1'b0;
      oy_q  <= '0;
      row_q <= '0;
      vb_q  <= 1'b0;
    end else begin
      ox_q  <= ox_d;
      col_q <= col_d;
      hb_q  <= hb_d;
      oy_q  <= oy_d;
      row_q <= row_d;
      vb_q  <= vb_d;
    end
  end

  slot_table #(.N(N)) u_table (
    .clk         (clk_25MHz),
    .rst_n       (rst_n),
    .wr_en_i     (wr_en),
    .wr_slot_i   (wr_slot),
    .wr_type_i   (wr_type),
    .wr_commit_i (wr_commit),
    .copy_i      ((h_cnt == '0) && (v_cnt == 10'd480)),
    .rd_slot_i   (slot),
    .rd_type_o   (rd_type),
    .pending_o   (commit_pending)
  );

  always_comb begin
    in_board = hb_d && vb_d;
    ring = (ox_d == '0) || (ox_d == 6'(PITCH_X - 1))
        || (oy_d == '0) || (oy_d == 6'(PITCH_Y - 1));
    slot = 6'(int'(row_d) * COLS + int'(col_d));
    s1_d.valid    = valid;
    s1_d.in_board = in_board;
    s1_d.ring     = ring;
    s1_d.selected = sel_en && (slot == sel_slot);
    s1_d.card     = in_board && !ring;
    px_d   = s1_d.card ? ox_d - 6'd1 : '0;
    py_d   = s1_d.card ? oy_d - 6'd1 : '0;
    type_d = in_board ? rd_type : CARD_EMPTY;
  end

  // Stage 1 drives the ROM; stage 2 sideband lines up with card_pixel
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      px_q    <= '0;
      py_q    <= '0;
      type_q  <= CARD_EMPTY;
      s1_q    <= '0;
      s2_q    <= '0;
      type2_q <= CARD_EMPTY;
      rgb_q   <= RGB_BLANK;
    end else begin
      px_q    <= px_d;
      py_q    <= py_d;
      type_q  <= type_d;
      s1_q    <= s1_d;
      s2_q    <= s1_q;
      type2_q <= type_q;
      rgb_q   <= rgb_d;
    end
  end

  always_comb begin
    rgb_d = mem.card_pixel;
    if (!s2_q.valid)
      rgb_d = RGB_BLANK;
    else if (!s2_q.in_board)
      rgb_d = BG;
    else if (s2_q.ring && s2_q.selected)
      rgb_d = SEL_RGB;
    else if (!s2_q.card)
      rgb_d = BG;
    else if (type2_q == CARD_EMPTY)
      rgb_d = BG;
  end

  assign mem.pixel_x   = px_q;
  assign mem.pixel_y   = py_q;
  assign mem.card_type = type_q;
  assign vga_rgb       = rgb_q;

endmodule

// File: tb/tb_card_board_scanner.sv
// Scoreboard bench for card_board_scanner: compressed frames, ROM model.
// Stimulus pushes expectations; a negedge monitor pops and compares.
module tb_card_board_scanner;
  import card_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  h = '0, v = '0;
  logic        vld = 1'b0;
  logic        wr_en = 1'b0, wr_commit = 1'b0;
  logic [5:0]  wr_slot = '0, wr_type = '0;
  logic        sel_en = 1'b0;
  logic [5:0]  sel_slot = '0;
  logic [11:0] rgb;
  logic        pend;

  card_board_scanner_if mem ();

  card_board_scanner dut (
    .clk_25MHz      (clk),
    .rst_n          (rst_n),
    .h_cnt          (h),
    .v_cnt          (v),
    .valid          (vld),
    .wr_en          (wr_en),
    .wr_slot        (wr_slot),
    .wr_type        (wr_type),
    .wr_commit      (wr_commit),
    .sel_en         (sel_en),
    .sel_slot       (sel_slot),
    .mem            (mem),
    .vga_rgb        (rgb),
    .commit_pending (pend)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] rom(logic [5:0] t, logic [5:0] x,
                                      logic [5:0] y);
    return {t[3:0], x[3:0], y[3:0]};
  endfunction

  always @(posedge clk)
    mem.card_pixel <= rom(mem.card_type, mem.pixel_x, mem.pixel_y);

  typedef struct {
    int          cyc;
    int          k;
    logic [17:0] e;
    logic [17:0] m;
    string       n;
  } exp_t;

  typedef struct {
    int          f;
    int          h;
    int          v;
    int          k;
    logic [17:0] e;
    string       n;
  } spot_t;

  exp_t  q1[$];
  exp_t  q3[$];
  spot_t spots[$];

  int cyc = 0;
  int checks = 0;
  int passed = 0;
  int frame = 0;

  logic [5:0] sh_m [54];
  logic [5:0] ac_m [54];
  bit pend_m;
  bit armed_m;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string n, logic [17:0] act, logic [17:0] e);
    checks++;
    if (act === e) passed++;
    else $display("FAIL %s cyc=%0d got=%h exp=%h", n, cyc, act, e);
  endtask

  always @(negedge clk) begin : mon
    exp_t r;
    while (q1.size() > 0 && q1[0].cyc < cyc) begin
      r = q1.pop_front();
      chk({"stale_", r.n}, 18'd1, 18'd0);
    end
    while (q1.size() > 0 && q1[0].cyc == cyc) begin
      r = q1.pop_front();
      if (r.k == 0)
        chk(r.n, {mem.card_type, mem.pixel_x, mem.pixel_y} & r.m,
            r.e & r.m);
      else
        chk(r.n, 18'(pend), r.e);
    end
    while (q3.size() > 0 && q3[0].cyc < cyc) begin
      r = q3.pop_front();
      chk({"stale_", r.n}, 18'd1, 18'd0);
    end
    while (q3.size() > 0 && q3[0].cyc == cyc) begin
      r = q3.pop_front();
      chk(r.n, 18'(rgb), r.e);
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 54; i++) begin
      sh_m[i] = 6'd63;
      ac_m[i] = 6'd63;
    end
    pend_m  = 1'b0;
    armed_m = 1'b0;
  endtask

  task automatic add_spot(int f, int hh, int vv, int k, logic [17:0] e,
                          string n);
    spot_t s;
    s.f = f; s.h = hh; s.v = vv; s.k = k; s.e = e; s.n = n;
    spots.push_back(s);
  endtask

  task automatic push(int dly, int k, logic [17:0] e, logic [17:0] m,
                      string n);
    exp_t r;
    r.cyc = cyc + dly; r.k = k; r.e = e; r.m = m; r.n = n;
    if (dly == 3) q3.push_back(r);
    else q1.push_back(r);
  endtask

  task automatic tick();
    int hi, vi, ox, oy, col, row, slot;
    bit hb, vb, inb, ring;
    logic [5:0]  t, px, py;
    logic [11:0] er;
    hi  = int'(h);
    vi  = int'(v);
    vld = (v < 10'd480) && (h < 10'd640);
    if (hi == 0 && vi == 300) armed_m = 1'b1;
    vb  = armed_m && vi >= 300 && vi < 300 + 3 * 48;
    hb  = hi >= 14 && hi < 14 + 18 * 34;
    inb = hb && vb;
    t = 6'd63; px = '0; py = '0; ring = 1'b1; slot = 0;
    if (inb) begin
      ox   = (hi - 14) % 34;
      col  = (hi - 14) / 34;
      oy   = (vi - 300) % 48;
      row  = (vi - 300) / 48;
      slot = row * 18 + col;
      ring = ox == 0 || ox == 33 || oy == 0 || oy == 47;
      t    = ac_m[slot];
      px   = 6'(ox - 1);
      py   = 6'(oy - 1);
    end
    if (!vld) er = 12'h000;
    else if (!inb) er = 12'h264;
    else if (ring && sel_en && slot == int'(sel_slot)) er = 12'hFF0;
    else if (ring) er = 12'h264;
    else if (t == 6'd63) er = 12'h264;
    else er = rom(t, px, py);
    push(1, 0, {t, px, py}, (inb && !ring) ? '1 : 18'h3F000, "pix");
    push(3, 2, 18'(er), '1, "vga");
    foreach (spots[i])
      if (spots[i].f == frame && spots[i].h == hi && spots[i].v == vi)
        push(spots[i].k == 2 ? 3 : 1, spots[i].k, spots[i].e, '1,
             spots[i].n);
    if (hi == 0 && vi == 480 && (pend_m || wr_commit)) begin
      ac_m   = sh_m;
      pend_m = 1'b0;
    end else if (wr_commit) begin
      pend_m = 1'b1;
    end
    if (wr_en && wr_slot < 6'd54) sh_m[wr_slot] = wr_type;
    push(1, 1, 18'(pend_m), '1, "pend");
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_rgb",  18'(rgb), 18'd0);
    chk("rst_type", 18'(mem.card_type), 18'd63);
    chk("rst_px",   18'(mem.pixel_x), 18'd0);
    chk("rst_py",   18'(mem.pixel_y), 18'd0);
    chk("rst_pend", 18'(pend), 18'd0);
    q1.delete();
    q3.delete();
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic bit full(int f, int vv);
    case (f)
      0: return vv == 301;
      1: return vv inside {250, 300, 301, 349, 394};
      2: return vv inside {301, 320, 349};
      default: return vv == 301;
    endcase
  endfunction

  task automatic set_ctl(int f, int vv);
    wr_en = 1'b0; wr_commit = 1'b0;
    sel_en = (f == 1); sel_slot = 6'd2;
    case (f)
      0: begin
        if (vv == 10) begin wr_en = 1; wr_slot = 0;  wr_type = 5;  end
        if (vv == 11) begin wr_en = 1; wr_slot = 19; wr_type = 54; end
        if (vv == 12) begin wr_en = 1; wr_slot = 60; wr_type = 7;  end
        if (vv == 13) wr_commit = 1;
      end
      1: begin
        if (vv == 100) begin wr_en = 1; wr_slot = 0; wr_type = 9;  end
        if (vv == 200) wr_commit = 1;
        if (vv == 480) begin wr_en = 1; wr_slot = 1; wr_type = 11; end
      end
      2: begin
        if (vv == 400) begin wr_en = 1; wr_slot = 0; wr_type = 12; end
        if (vv == 401) wr_commit = 1;
      end
      default: ;
    endcase
  endtask

  task automatic run_frame(int f);
    frame = f;
    for (int vv = 0; vv < 525; vv++) begin
      v = 10'(vv);
      set_ctl(f, vv);
      if (full(f, vv)) begin
        for (int hh = 0; hh < 650; hh++) begin
          h = 10'(hh);
          if (f == 2 && vv == 320 && hh == 200) do_reset();
          tick();
        end
      end else begin
        h = '0;
        tick();
      end
    end
    wr_en = 1'b0; wr_commit = 1'b0;
  endtask

  initial begin
    model_reset();
    add_spot(0, 0,   14,  1, 18'd1, "f0_pend_set");
    add_spot(0, 15,  301, 0, {6'd63, 12'd0}, "f0_not_yet");
    add_spot(0, 15,  301, 2, 18'h264, "f0_rgb_bg");
    add_spot(1, 15,  250, 0, {6'd63, 12'd0}, "f1_above");
    add_spot(1, 15,  301, 0, {6'd5, 12'd0}, "f1_slot0");
    add_spot(1, 15,  301, 2, 18'h500, "f1_slot0_rgb");
    add_spot(1, 49,  349, 0, {6'd54, 12'd0}, "f1_slot19");
    add_spot(1, 80,  394, 0, {6'd54, 6'd31, 6'd45}, "f1_corner");
    add_spot(1, 80,  394, 2, 18'h6FD, "f1_corner_rgb");
    add_spot(1, 82,  301, 2, 18'hFF0, "f1_sel_left");
    add_spot(1, 99,  300, 2, 18'hFF0, "f1_sel_top");
    add_spot(1, 116, 301, 2, 18'h264, "f1_slot3_ring");
    add_spot(1, 194, 301, 2, 18'h264, "f1_empty");
    add_spot(1, 5,   301, 2, 18'h264, "f1_left_out");
    add_spot(1, 645, 301, 2, 18'h000, "f1_invalid");
    add_spot(1, 0,   150, 1, 18'd0, "f1_nocommit");
    add_spot(1, 0,   201, 1, 18'd1, "f1_pend_on");
    add_spot(1, 0,   479, 1, 18'd1, "f1_pend_hold");
    add_spot(1, 0,   481, 1, 18'd0, "f1_pend_off");
    add_spot(2, 15,  301, 0, {6'd9, 12'd0}, "f2_slot0");
    add_spot(2, 49,  301, 0, {6'd63, 12'd0}, "f2_copy_wr");
    add_spot(2, 49,  301, 2, 18'h264, "f2_copy_wr_rgb");
    add_spot(2, 49,  349, 0, {6'd63, 12'd0}, "f2_after_rst");
    add_spot(2, 60,  349, 2, 18'h264, "f2_after_rst_rgb");
    add_spot(3, 15,  301, 0, {6'd12, 12'd0}, "f3_slot0");
    add_spot(3, 15,  301, 2, 18'hC00, "f3_slot0_rgb");

    repeat (3) @(posedge clk);
    #1;
    chk("init_rgb",  18'(rgb), 18'd0);
    chk("init_type", 18'(mem.card_type), 18'd63);
    chk("init_px",   18'(mem.pixel_x), 18'd0);
    chk("init_py",   18'(mem.pixel_y), 18'd0);
    chk("init_pend", 18'(pend), 18'd0);
    rst_n = 1'b1;

    for (int f = 0; f < 4; f++) run_frame(f);

    h = '0; v = '0; vld = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("drain", 18'(q1.size() + q3.size()), 18'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
